uart_tx_io: RTL and testbench
=============================

# uart_tx_io

Memory-mapped UART transmitter sitting on the core's IO bus, directly downstream of the CPU's IO store path in `SOC`. It consumes IO write strobes and data, buffers bytes in a small FIFO, and serialises them as 8N1 frames on `tx`. It drives the IO read data so software can poll status through ordinary IO loads.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: input clock frequency.
- `BAUD`, default 115_200: line rate.
- `DIV`, derived as `CLK_FREQ_HZ/BAUD` (truncated): clocks per bit. Must be ≥ 2; elaboration fails otherwise.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `io_wordaddr`  in  14  IO word address, equal to `IO_mem_addr[15:2]`.
- `io_wdata`  in  32  IO write data.
- `io_wr`  in  1  IO write strobe, one cycle per store.
- `io_rdata`  out  32  IO read data, combinational from `io_wordaddr`.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- Address decode is one-hot on word-address bits:
  - `io_wordaddr[1]` selects DATA.
  - `io_wordaddr[2]` selects STATUS.
  - If both bits are set, DATA takes precedence for writes, and `io_rdata` returns STATUS.
- DATA write: when `io_wr & io_wordaddr[1]`, push `io_wdata[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - A full-FIFO push is dropped even if a pop happens in the same cycle.
- STATUS write: when `io_wr & io_wordaddr[2] & io_wdata[3]`, clear `ovf`.
  - If a set and a clear of `ovf` occur in the same cycle, set wins.
- STATUS read: `io_rdata = {28'b0, ovf, full, !empty, busy}`.
  - `busy` = FSM not in IDLE.
  - All other addresses read 0.
- TX FSM has states IDLE, START, DATA, STOP, driven by a baud counter `bcnt` (width `$clog2(DIV)`) and a bit index `bidx` (3 bits).
  - IDLE: `tx=1`. If FIFO not empty: pop, load shift register, `bcnt<=DIV-1`, `tx<=0`, go to START.
  - START: when `bcnt==0`: `tx<=sh[0]`, `bidx<=0`, `bcnt<=DIV-1`, go to DATA. Otherwise decrement `bcnt`.
  - DATA: when `bcnt==0`:
    - if `bidx==7`: `tx<=1`, `bcnt<=DIV-1`, go to STOP;
    - else shift right, `tx<=next bit`, increment `bidx`.
  - STOP: when `bcnt==0`, go to IDLE (no extra cycle at `tx=1` beyond the stop bit).
- Bits go out LSB first.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.
  - `full` = MSBs differ and the low bits are equal.
  - `empty` = pointers equal.
  - A simultaneous push (non-full) and pop keeps occupancy unchanged.

## Timing
- Reset values: `tx=1`, state IDLE, FIFO empty, `ovf=0`, `bcnt=0`, `bidx=0`. `io_rdata` then reads 0 at STATUS.
- Write at edge E0 makes the FIFO non-empty after E0.
- If IDLE, the pop occurs at E1 and `tx` falls at E1.
- Start bit, each data bit and the stop bit each last exactly `DIV` cycles. A frame lasts `10*DIV` cycles.
- Back-to-back frames: one IDLE cycle between the end of the stop bit and the next start bit, so `10*DIV+1` cycles per byte.
- STATUS reflects registered state with zero-cycle read latency. A push at E0 is visible in `!empty` after E0.
- Reset asserted mid-frame: `tx=1` at the next edge, the FIFO is flushed, and the frame is truncated. No partial resume.
- Throughput limit: the core can issue a store every cycle. Software must poll `full`; excess bytes set `ovf`.

## Structure
- Package `uart_pkg`:
  - state enum `{IDLE, START, DATA, STOP}`;
  - address bit constants `UART_DATA_BIT=1`, `UART_STAT_BIT=2`;
  - STATUS bit positions `ST_BUSY=0`, `ST_NEMPTY=1`, `ST_FULL=2`, `ST_OVF=3`.
- One sub-module, `sync_fifo`, parameterised `WIDTH=8`, `DEPTH`:
  - ports `push`, `din`, `pop`, `dout`, `full`, `empty`;
  - first-word-fall-through, with `dout` valid whenever `!empty`.
- FSM, baud counter and register decode live in `uart_tx_io`.

## Test plan
All scenarios use `CLK_FREQ_HZ=400`, `BAUD=100`, so `DIV=4`.
- Reset: hold `resetn=0` 3 cycles -> `tx=1`, and STATUS read = 0x0.
- Single byte 0x55 written at E0 -> `tx` falls at E1. Over 40 cycles `tx` shows 0,1,0,1,0,1,0,1,0,1 (each 4 cycles), then returns high. `busy` is 1 for exactly 40 cycles.
- Write 0x41, 0x42, 0x43 on consecutive cycles -> frames start at E1, E42, E83. Decoded bytes are 0x41, 0x42, 0x43. STATUS bit1 drops after the third pop.
- Overflow:
  - write 10 bytes on consecutive cycles with `FIFO_DEPTH=8`, so one byte is popped at E1 -> exactly 9 bytes transmitted, STATUS = 0xF while full;
  - `ovf` stays set until a STATUS write with `wdata=0x8`, then reads 0.
- Reset mid-frame: assert `resetn=0` during data bit 3 of 0xA5 with 2 bytes queued -> `tx=1` next edge, FIFO empty, nothing transmitted after release.
- Decode: write 0x7E to STATUS only and to address bit0 -> no frame starts. Read of an unmapped word -> `io_rdata=0`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the IO-mapped UART transmitter.
//   tx_state_t    : transmit FSM state encoding
//   UART_*_BIT    : word-address bits that select the DATA / STATUS registers
//   ST_*          : bit positions inside the STATUS read word
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_DATA_BIT = 1;
  localparam int UART_STAT_BIT = 2;

  localparam int ST_BUSY   = 0;
  localparam int ST_NEMPTY = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_OVF    = 3;

endpackage

// File: rtl/uart_tx_io_sync_fifo.sv
// First-word-fall-through synchronous FIFO: dout is valid whenever !empty.
//   clk, resetn : clock, synchronous active-low reset (flushes contents)
//   push, din   : write request and data; ignored while full
//   pop, dout   : read request and head-of-queue data; ignored while empty
//   full, empty : occupancy flags derived from the extra pointer MSB
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the core IO bus.
//   clk, resetn  : clock, synchronous active-low reset
//   io_wordaddr  : IO word address (bit1 = DATA, bit2 = STATUS)
//   io_wdata     : IO write data
//   io_wr        : one-cycle IO write strobe
//   io_rdata     : combinational read data, STATUS = {ovf, full, !empty, busy}
//   tx           : registered serial output, idle high, LSB first
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | driving the start bit (low) for DIV cycles
// DATA  | shifting out 8 data bits, DIV cycles each
// STOP  | driving the stop bit (high) for DIV cycles
module uart_tx_io
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] io_wordaddr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  output logic        tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BCNT_TOP = BW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_io: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  tx_state_t   state;
  logic [BW-1:0] bcnt;
  logic [2:0]  bidx;
  logic [7:0]  sh;
  logic        ovf;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        sel_data;
  logic        sel_stat;
  logic        ovf_set;
  logic        ovf_clr;
  logic [31:0] status;

  assign sel_data  = io_wordaddr[UART_DATA_BIT];
  assign sel_stat  = io_wordaddr[UART_STAT_BIT];
  assign fifo_push = io_wr & sel_data;
  // DATA wins a write that hits both registers, so STATUS side effects are masked.
  assign ovf_set   = fifo_push & fifo_full;
  assign ovf_clr   = io_wr & sel_stat & ~sel_data & io_wdata[3];
  assign fifo_pop  = (state == IDLE) & ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (io_wdata[7:0]),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    status            = '0;
    status[ST_BUSY]   = (state != IDLE);
    status[ST_NEMPTY] = ~fifo_empty;
    status[ST_FULL]   = fifo_full;
    status[ST_OVF]    = ovf;
    io_rdata          = sel_stat ? status : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      tx    <= 1'b1;
      bcnt  <= '0;
      bidx  <= '0;
      sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            sh    <= fifo_dout;
            bcnt  <= BCNT_TOP;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bcnt == '0) begin
            tx    <= sh[0];
            bidx  <= '0;
            bcnt  <= BCNT_TOP;
            state <= DATA;
          end else begin
            bcnt <= bcnt - BW'(1);
          end
        end
        DATA: begin
          if (bcnt == '0) begin
            bcnt <= BCNT_TOP;
            if (bidx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              sh   <= {1'b0, sh[7:1]};
              tx   <= sh[1];
              bidx <= bidx + 3'd1;
            end
          end else begin
            bcnt <= bcnt - BW'(1);
          end
        end
        STOP: begin
          // Return straight to IDLE; IDLE itself supplies the single gap cycle.
          if (bcnt == '0) begin
            state <= IDLE;
          end else begin
            bcnt <= bcnt - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io_wdata[31:8], io_wordaddr[13:3], io_wordaddr[0]};

endmodule

// File: tb/tb_uart_tx_io.sv
module tb_uart_tx_io;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] io_wordaddr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_wr = 1'b0;
  logic [31:0] io_rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_io #(
    .CLK_FREQ_HZ (400),
    .BAUD        (100),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .io_wordaddr (io_wordaddr),
    .io_wdata    (io_wdata),
    .io_wr       (io_wr),
    .io_rdata    (io_rdata),
    .tx          (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected frames: byte value and the cycle count at which tx must fall (-1 = any).
  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [13:0] wa;
    logic [31:0] wd;
    logic        wr;
    logic [13:0] ra;
    logic [31:0] exp_rd;
    logic        exp_tx;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives one write cycle and returns at the next falling edge.
  task automatic wr(input logic [13:0] a, input logic [31:0] d, output int e0);
    e0 = cyc + 1;
    io_wordaddr = a;
    io_wdata    = d;
    io_wr       = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (6) @(negedge clk);
    io_wordaddr = 14'h4;
    #1;
    chk("drain_status", io_rdata, 32'h0);
  endtask

  // Line receiver: samples mid-bit on falling edges, compares against the scoreboard.
  logic       mact = 1'b0;
  int         mcnt = 0;
  int         mstart = 0;
  logic [9:0] mbits = '0;
  exp_t       mexp;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mact = 1'b0;
      end else if (!mact) begin
        if (tx === 1'b0) begin
          mact   = 1'b1;
          mcnt   = 0;
          mstart = cyc;
        end
      end else begin
        mcnt++;
        if (mcnt % 4 == 2) mbits[mcnt/4] = tx;
        if (mcnt == 38) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame actual=%0h at cycle %0d required=none", mbits, mstart);
          end else begin
            mexp = sb.pop_front();
            if (mbits[0] !== 1'b0 || mbits[9] !== 1'b1 || mbits[8:1] !== mexp.data ||
                (mexp.start >= 0 && mstart != mexp.start)) begin
              errors++;
              $display("FAIL frame actual=%0h start=%0d expected=%0h start=%0d (bits %b)",
                       mbits[8:1], mstart, mexp.data, mexp.start, mbits);
            end
          end
        end
        if (mcnt == 39) mact = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e;
    logic [9:0] f;
    logic [31:0] exp_st;

    vecs[0] = '{wa: 14'h0, wd: 32'h0,  wr: 1'b0, ra: 14'h4,    exp_rd: 32'h0, exp_tx: 1'b1};
    vecs[1] = '{wa: 14'h4, wd: 32'h7E, wr: 1'b1, ra: 14'h4,    exp_rd: 32'h0, exp_tx: 1'b1};
    vecs[2] = '{wa: 14'h1, wd: 32'h7E, wr: 1'b1, ra: 14'h4,    exp_rd: 32'h0, exp_tx: 1'b1};
    vecs[3] = '{wa: 14'h0, wd: 32'h0,  wr: 1'b0, ra: 14'h0,    exp_rd: 32'h0, exp_tx: 1'b1};
    vecs[4] = '{wa: 14'h0, wd: 32'h0,  wr: 1'b0, ra: 14'h3FF9, exp_rd: 32'h0, exp_tx: 1'b1};
    vecs[5] = '{wa: 14'h0, wd: 32'h0,  wr: 1'b0, ra: 14'h2,    exp_rd: 32'h0, exp_tx: 1'b1};
    vecs[6] = '{wa: 14'h0, wd: 32'h0,  wr: 1'b0, ra: 14'h6,    exp_rd: 32'h0, exp_tx: 1'b1};

    // Reset held for 3 cycles.
    io_wordaddr = 14'h4;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_status", io_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Decode table: nothing here may start a frame.
    for (int i = 0; i < 7; i++) begin
      io_wordaddr = vecs[i].wa;
      io_wdata    = vecs[i].wd;
      io_wr       = vecs[i].wr;
      @(negedge clk);
      io_wr       = 1'b0;
      io_wordaddr = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_tx", i), tx, vecs[i].exp_tx);
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    io_wordaddr = 14'h4;
    #1;
    chk("decode_idle_status", io_rdata, 32'h0);
    chk("decode_idle_tx", tx, 1'b1);
    @(negedge clk);

    // Single byte 0x55: cycle-accurate waveform and busy window.
    wr(14'h2, 32'h55, e0);
    sb.push_back('{data: 8'h55, start: e0 + 1});
    f = {1'b1, 8'h55, 1'b0};
    io_wordaddr = 14'h4;
    for (int j = 0; j < 46; j++) begin
      #1;
      if (j >= 1 && j <= 40) chk($sformatf("b55_tx_%0d", j), tx, f[(j-1)/4]);
      else                   chk($sformatf("b55_tx_%0d", j), tx, 1'b1);
      exp_st = 32'h0;
      if (j >= 1 && j <= 40) exp_st[0] = 1'b1;
      if (j == 0)            exp_st[1] = 1'b1;
      chk($sformatf("b55_status_%0d", j), io_rdata, exp_st);
      @(negedge clk);
    end
    drain(100);
    @(negedge clk);

    // Three back-to-back bytes: frames 41 cycles apart, nonempty drops at third pop.
    wr(14'h2, 32'h41, e0);
    wr(14'h2, 32'h42, e);
    wr(14'h2, 32'h43, e);
    sb.push_back('{data: 8'h41, start: e0 + 1});
    sb.push_back('{data: 8'h42, start: e0 + 42});
    sb.push_back('{data: 8'h43, start: e0 + 83});
    io_wordaddr = 14'h4;
    repeat (80) @(negedge clk);
    #1;
    chk("three_nempty_before", io_rdata[1], 1'b1);
    @(negedge clk);
    #1;
    chk("three_nempty_after", io_rdata[1], 1'b0);
    @(negedge clk);
    drain(300);
    @(negedge clk);

    // Overflow: ten consecutive writes, one popped early, the tenth dropped.
    for (int k = 0; k < 10; k++) begin
      wr(14'h2, 32'h10 + k, e);
      if (k == 0) e0 = e;
      if (k < 9) sb.push_back('{data: 8'(8'h10 + k), start: e0 + 1 + 41 * k});
    end
    io_wordaddr = 14'h4;
    #1;
    chk("ovf_full_status", io_rdata, 32'hF);
    @(negedge clk);
    repeat (40) @(negedge clk);
    #1;
    chk("ovf_sticky_notfull", io_rdata, 32'hB);
    @(negedge clk);
    // Write hitting both registers: treated as DATA, ovf untouched.
    wr(14'h6, 32'h08, e);
    sb.push_back('{data: 8'h08, start: e0 + 1 + 41 * 9});
    io_wordaddr = 14'h4;
    #1;
    chk("both_bits_write", io_rdata, 32'hF);
    @(negedge clk);
    wr(14'h4, 32'h07, e);
    io_wordaddr = 14'h4;
    #1;
    chk("ovf_clear_nobit3", io_rdata, 32'hF);
    @(negedge clk);
    wr(14'h4, 32'h08, e);
    io_wordaddr = 14'h4;
    #1;
    chk("ovf_clear", io_rdata, 32'h7);
    @(negedge clk);
    drain(600);
    @(negedge clk);

    // Reset during data bit 3 of 0xA5 with two more bytes queued.
    wr(14'h2, 32'hA5, e0);
    wr(14'h2, 32'h01, e);
    wr(14'h2, 32'h02, e);
    repeat (16) @(negedge clk);
    chk("midframe_bit3", tx, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    io_wordaddr = 14'h4;
    #1;
    chk("midframe_reset_tx", tx, 1'b1);
    chk("midframe_reset_status", io_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("midframe_after_status", io_rdata, 32'h0);
    chk("midframe_after_tx", tx, 1'b1);
    chk("midframe_no_pending", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
